// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response handshake bundle for the SRAM port controller.
// master drives requests and consumes responses; slave is the controller side.
interface sram_rw_port_ctrl_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_rw_port_ctrl.sv
// Single-port SRAM controller: one write per cycle, reads return after 2 cycles, plus a full-array fill.
// Requests stall while a response is unconsumed, a read is in flight, or a fill is running.
module sram_rw_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  sram_rw_port_ctrl_if.slave    bus,
  input  logic                  clr_start,
  input  logic [DATA_WIDTH-1:0] clr_data,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, CLEAR} state_t;

  state_t                state_q, state_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DATA_WIDTH-1:0] clr_data_q, clr_data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  req_fire;
  logic                  rsp_take;

  assign bus.req_ready = (state_q == IDLE) && !clr_start && (!rsp_vld_q || bus.rsp_ready);
  assign req_fire      = bus.req_valid && bus.req_ready;
  assign rsp_take      = rsp_vld_q && bus.rsp_ready;

  always_comb begin
    state_d    = state_q;
    csb_d      = 1'b1;
    web_d      = 1'b1;
    addr_d     = addr_q;
    din_d      = din_q;
    cnt_d      = cnt_q;
    clr_data_d = clr_data_q;
    rdata_d    = rdata_q;
    rsp_vld_d  = rsp_vld_q && !rsp_take;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A fill request beats a same-edge access request.
        if (clr_start) begin
          state_d    = CLEAR;
          busy_d     = 1'b1;
          clr_data_d = clr_data;
          cnt_d      = '0;
          csb_d      = 1'b0;
          web_d      = 1'b0;
          addr_d     = '0;
          din_d      = clr_data;
        end else if (req_fire) begin
          csb_d  = 1'b0;
          web_d  = !bus.req_we;
          addr_d = bus.req_addr;
          if (bus.req_we) begin
            din_d = bus.req_wdata;
          end else begin
            state_d = RD1;
          end
        end
      end
      RD1: state_d = RD2;
      RD2: begin
        state_d   = IDLE;
        rdata_d   = sram_dout0;
        rsp_vld_d = 1'b1;
      end
      CLEAR: begin
        // cnt_q holds the address issued last edge; stop once the top word has gone out.
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + ADDR_WIDTH'(1);
          csb_d  = 1'b0;
          web_d  = 1'b0;
          addr_d = cnt_q + ADDR_WIDTH'(1);
          din_d  = clr_data_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      cnt_q      <= '0;
      clr_data_q <= '0;
      rdata_q    <= '0;
      rsp_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      clr_data_q <= clr_data_d;
      rdata_q    <= rdata_d;
      rsp_vld_q  <= rsp_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sram_csb0     = csb_q;
  assign sram_web0     = web_q;
  assign sram_addr0    = addr_q;
  assign sram_din0     = din_q;
  assign bus.rsp_valid = rsp_vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign busy          = busy_q;
  assign clr_done      = done_q;

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Bench for sram_rw_port_ctrl: behavioural SRAM plus a word-array reference of expected contents.
module tb_sram_rw_port_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_data = '0;
  logic          busy, clr_done, sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem  [DEPTH];
  logic [DW-1:0] sram_mem [DEPTH];

  sram_rw_port_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sram_rw_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .busy      (busy),
    .clr_done  (clr_done),
    .sram_csb0 (sram_csb0),
    .sram_web0 (sram_web0),
    .sram_addr0(sram_addr0),
    .sram_din0 (sram_din0),
    .sram_dout0(sram_dout0)
  );

  always #5 clk = ~clk;

  // Synchronous 1RW macro: samples at the edge after the controller drives, data usable one edge later.
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) sram_mem[sram_addr0] <= sram_din0;
      else            sram_dout0 <= sram_mem[sram_addr0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the handshake edge; returns just after that edge.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic acc;
    int   waited;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    acc    = 1'b0;
    waited = 0;
    while (!acc && waited < 100) begin
      #1;
      acc = (bus.req_ready === 1'b1);
      tick();
      waited++;
    end
    bus.req_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout addr=%h we=%b never accepted within 100 cycles", a, we);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    issue(1'b1, a, d);
    checks++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== a || sram_din0 !== d) begin
      errors++;
      $display("FAIL write_drive csb=%b web=%b addr=%h din=%h, want 0 0 %h %h",
               sram_csb0, sram_web0, sram_addr0, sram_din0, a, d);
    end
    ref_mem[a] = d;
  endtask

  task automatic do_read_stall(input logic [AW-1:0] a, input int stall);
    int            lat;
    logic [DW-1:0] exp;
    exp = ref_mem[a];
    bus.rsp_ready = 1'b0;
    issue(1'b0, a, '0);
    checks++;
    if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b1 || sram_addr0 !== a) begin
      errors++;
      $display("FAIL read_drive csb=%b web=%b addr=%h, want 0 1 %h", sram_csb0, sram_web0, sram_addr0, a);
    end
    wait_rsp(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL read_latency addr=%h got %0d cycles, want 2", a, lat);
    end
    checks++;
    if (bus.rsp_rdata !== exp) begin
      errors++;
      $display("FAIL read_data addr=%h got %h, want %h", a, bus.rsp_rdata, exp);
    end
    for (int s = 0; s < stall; s++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp) begin
        errors++;
        $display("FAIL rsp_hold addr=%h valid=%b data=%h, want 1 %h", a, bus.rsp_valid, bus.rsp_rdata, exp);
      end
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rsp_take addr=%h valid=%b after take, want 0", a, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_addr0 !== '0 || sram_din0 !== '0) begin
      errors++;
      $display("FAIL reset_sram csb=%b web=%b addr=%h din=%h, want 1 1 0 0", sram_csb0, sram_web0, sram_addr0, sram_din0);
    end
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== '0 || busy !== 1'b0 || clr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_status rsp_valid=%b rdata=%h busy=%b done=%b, want 0 0 0 0",
               bus.rsp_valid, bus.rsp_rdata, busy, clr_done);
    end
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b, want 1", bus.req_ready);
    end
    tick();
  endtask

  task automatic test_write_read();
    do_write(10'h3FF, 8'h5A);
    do_read_stall(10'h3FF, 0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = DW'(8'h11 * (i + 1));
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = AW'(i);
      bus.req_wdata = d;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready beat %0d got %b, want 1", i, bus.req_ready);
      end
      tick();
      checks++;
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(i) || sram_din0 !== d) begin
        errors++;
        $display("FAIL b2b_drive beat %0d csb=%b web=%b addr=%h din=%h, want 0 0 %h %h",
                 i, sram_csb0, sram_web0, sram_addr0, sram_din0, i, d);
      end
      ref_mem[i] = d;
    end
    bus.req_valid = 1'b0;
    tick();
    checks++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release csb=%b web=%b, want 1 1", sram_csb0, sram_web0);
    end
    for (int i = 0; i < 4; i++) do_read_stall(AW'(i), 0);
  endtask

  task automatic test_backpressure();
    int lat;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'h002, '0);
    wait_rsp(lat);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'h001;
    for (int s = 0; s < 5; s++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ref_mem[2] || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d valid=%b data=%h ready=%b, want 1 %h 0",
                 s, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, ref_mem[2]);
      end
      tick();
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_take_ready got %b, want 1", bus.req_ready);
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_take_valid got %b, want 0", bus.rsp_valid);
    end
  endtask

  task automatic test_clear();
    int lat, cyc, busy_cnt, addr_err;
    // Leave a response pending across the fill.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'h3FF, '0);
    wait_rsp(lat);
    clr_data      = 8'hA5;
    clr_start     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 10'h010;
    bus.req_wdata = 8'h99;
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_prio_ready got %b, want 0", bus.req_ready);
    end
    tick();
    clr_start     = 1'b0;
    clr_data      = 8'h3C;
    bus.req_valid = 1'b0;
    cyc = 0; busy_cnt = 0; addr_err = 0;
    while (clr_done !== 1'b1 && cyc < 1100) begin
      if (busy === 1'b1) busy_cnt++;
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(cyc) || sram_din0 !== 8'hA5) addr_err++;
      if (cyc == 500) clr_start = 1'b1;
      if (cyc == 501) clr_start = 1'b0;
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== DEPTH) begin
      errors++;
      $display("FAIL clr_done_cycle got %0d, want %0d", cyc, DEPTH);
    end
    checks++;
    if (busy_cnt !== DEPTH) begin
      errors++;
      $display("FAIL clr_busy_cycles got %0d, want %0d", busy_cnt, DEPTH);
    end
    checks++;
    if (addr_err !== 0) begin
      errors++;
      $display("FAIL clr_sequence got %0d bad cycles, want 0", addr_err);
    end
    checks++;
    if (busy !== 1'b0 || sram_csb0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_end busy=%b csb=%b, want 0 1", busy, sram_csb0);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h5A) begin
      errors++;
      $display("FAIL clr_rsp_kept valid=%b data=%h, want 1 5a", bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
    checks++;
    if (clr_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_done_pulse got %b, want 0", clr_done);
    end
    bus.rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hA5;
    do_read_stall(10'h000, 0);
    do_read_stall(10'h200, 0);
    do_read_stall(10'h3FF, 0);
    do_read_stall(10'h010, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) a = AW'($urandom_range(0, 15));
      else                           a = AW'(DEPTH - 1 - int'($urandom_range(0, 15)));
      if ($urandom_range(0, 1) == 1) do_write(a, DW'($urandom));
      else                           do_read_stall(a, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid_read();
    bus.rsp_ready = 1'b1;
    issue(1'b0, 10'h3F0, '0);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || sram_csb0 !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_instant valid=%b csb=%b, want 0 1", bus.rsp_valid, sram_csb0);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_read_ready got %b, want 1", bus.req_ready);
    end
    begin
      int seen = 0;
      for (int s = 0; s < 4; s++) begin
        tick();
        if (bus.rsp_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL rst_read_discard got %0d cycles with rsp_valid, want 0", seen);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int k, done_seen;
    do_write(10'h0FF, 8'h11);
    do_write(10'h100, 8'h22);
    do_write(10'h101, 8'h77);
    clr_data  = 8'hA5;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    k = 0;
    while (sram_addr0 !== 10'h100 && k < 2000) begin
      tick();
      k++;
    end
    if (k >= 2000) begin
      checks++; errors++;
      $display("FAIL rst_clr_reach addr=%h never reached 100", sram_addr0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sram_csb0 !== 1'b1 || sram_web0 !== 1'b1 || sram_addr0 !== '0 || sram_din0 !== '0) begin
      errors++;
      $display("FAIL rst_clr_sram csb=%b web=%b addr=%h din=%h, want 1 1 0 0", sram_csb0, sram_web0, sram_addr0, sram_din0);
    end
    checks++;
    if (busy !== 1'b0 || clr_done !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_clr_status busy=%b done=%b valid=%b, want 0 0 0", busy, clr_done, bus.rsp_valid);
    end
    done_seen = 0;
    for (int s = 0; s < 3; s++) begin
      tick();
      if (clr_done !== 1'b0) done_seen++;
    end
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      if (clr_done !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL rst_clr_no_done got %0d cycles with clr_done, want 0", done_seen);
    end
    for (int i = 0; i < 16'h100; i++) ref_mem[i] = 8'hA5;
    do_read_stall(10'h0FF, 0);
    do_read_stall(10'h101, 0);
    do_read_stall(10'h000, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_random();
    test_reset_mid_read();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
